// File: rtl/soc_io_uart_tx_pkg.sv
// rtl/soc_io_uart_tx_pkg.sv - shared IO-page constants and TX state encoding
package soc_io_uart_tx_pkg;

    // Address bit that selects the IO page.
    localparam int IO_BIT = 22;

    // Word-offset bit indices, relative to mem_addr[2]. The word offset is
    // decoded one-hot, so each register owns one address bit.
    localparam int IO_LEDS_BIT      = 0;
    localparam int IO_UART_DAT_BIT  = 1;
    localparam int IO_UART_CNTL_BIT = 2;

    // Position of the busy flag in the UART_CNTL status word.
    localparam int UART_BUSY_BIT = 9;

    // TX FSM encoding.
    typedef logic [1:0] tx_state_t;
    localparam tx_state_t TX_IDLE  = 2'd0;
    localparam tx_state_t TX_START = 2'd1;
    localparam tx_state_t TX_DATA  = 2'd2;
    localparam tx_state_t TX_STOP  = 2'd3;

endpackage

// File: rtl/soc_io_uart_tx_if.sv
// rtl/soc_io_uart_tx_if.sv - CPU memory bus between the initiator and the IO responder
//
// Signals:
//   mem_addr   byte address from the CPU
//   mem_wdata  write data
//   mem_wmask  byte write enables; nonzero means write
//   mem_rstrb  one-cycle read strobe
//   mem_rdata  read data returned by the responder
interface soc_io_uart_tx_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_wmask,
        output mem_rstrb,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_wmask,
        input  mem_rstrb,
        output mem_rdata
    );
endinterface

// File: rtl/soc_io_uart_tx_core.sv
// rtl/soc_io_uart_tx_core.sv - 8N1 UART serialiser with valid/ready byte input
//
// Ports:
//   clk, resetn  clock and synchronous active-low reset
//   i_data       byte to transmit
//   i_valid      i_data is available
//   o_ready      core is idle; a byte is taken when i_valid && o_ready
//   o_txd        serial output, idle high
module uart_tx_core
    import soc_io_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_txd
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_t   r_state;
    tx_state_t   w_next_state;
    logic [BW-1:0] r_baud;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        w_baud_last;

    assign w_baud_last = (r_baud == BAUD_LAST);

    // State register plus the datapath that advances with it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= TX_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                TX_IDLE: begin
                    if (i_valid) begin
                        r_shift <= i_data;
                        r_baud  <= '0;
                        r_bit   <= '0;
                    end
                end
                TX_START: begin
                    if (w_baud_last) begin
                        r_baud <= '0;
                        r_bit  <= '0;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (w_baud_last) begin
                        r_baud  <= '0;
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    if (w_baud_last) begin
                        r_baud <= '0;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            TX_IDLE:  if (i_valid)                        w_next_state = TX_START;
            TX_START: if (w_baud_last)                    w_next_state = TX_DATA;
            TX_DATA:  if (w_baud_last && r_bit == 3'd7)   w_next_state = TX_STOP;
            TX_STOP:  if (w_baud_last)                    w_next_state = TX_IDLE;
            default:                                      w_next_state = TX_IDLE;
        endcase
    end

    // TXD comes straight off registered state so reset forces it high at once.
    always_comb begin
        o_txd   = 1'b1;
        o_ready = 1'b0;
        case (r_state)
            TX_IDLE:  o_ready = 1'b1;
            TX_START: o_txd   = 1'b0;
            TX_DATA:  o_txd   = r_shift[0];
            default:  o_txd   = 1'b1;
        endcase
    end

endmodule

// File: rtl/soc_io_uart_tx.sv
// rtl/soc_io_uart_tx.sv - IO-page responder: LED register, UART holding register and status read
//
// Ports:
//   clk, resetn  clock and synchronous active-low reset
//   bus          CPU memory bus, slave side (addr/wdata/wmask/rstrb in, rdata out)
//   leds         LED register, active-high
//   txd          UART serial output, idle high
module soc_io_uart_tx
    import soc_io_uart_tx_pkg::*;
#(
    parameter int CLK_FREQ     = 48000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic              clk,
    input  logic              resetn,
    soc_io_uart_tx_if.slave   bus,
    output logic [4:0]        leds,
    output logic              txd
);

    logic        w_io_sel;
    logic        w_wr;
    logic        w_rd;
    logic        w_sel_leds;
    logic        w_sel_dat;
    logic        w_sel_cntl;
    logic [31:0] w_rd_mux;
    logic [31:0] r_rdata;
    logic [4:0]  r_leds;
    logic [7:0]  r_hold;
    logic        r_hold_full;
    logic        w_tx_ready;
    logic        w_txd;
    logic        w_unused;

    assign w_io_sel   = bus.mem_addr[IO_BIT];
    assign w_wr       = w_io_sel && (|bus.mem_wmask);
    assign w_rd       = w_io_sel && bus.mem_rstrb;
    assign w_sel_leds = bus.mem_addr[2 + IO_LEDS_BIT];
    assign w_sel_dat  = bus.mem_addr[2 + IO_UART_DAT_BIT];
    assign w_sel_cntl = bus.mem_addr[2 + IO_UART_CNTL_BIT];

    assign w_unused = &{1'b0, bus.mem_addr[31:23], bus.mem_addr[21:5],
                        bus.mem_addr[1:0], bus.mem_wdata[31:8]};

    always_comb begin
        w_rd_mux = '0;
        if (w_sel_leds) begin
            w_rd_mux = {27'b0, r_leds};
        end else if (w_sel_cntl) begin
            w_rd_mux[UART_BUSY_BIT] = r_hold_full;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_leds      <= '0;
            r_rdata     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            if (w_wr && w_sel_leds) begin
                r_leds <= bus.mem_wdata[4:0];
            end
            // The core's unload wins over a same-cycle write; that write is
            // dropped because hold_full was still set when it was sampled.
            if (r_hold_full && w_tx_ready) begin
                r_hold_full <= 1'b0;
            end else if (w_wr && w_sel_dat && !r_hold_full) begin
                r_hold      <= bus.mem_wdata[7:0];
                r_hold_full <= 1'b1;
            end
            if (w_rd) begin
                r_rdata <= w_rd_mux;
            end
        end
    end

    uart_tx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_core (
        .clk     (clk),
        .resetn  (resetn),
        .i_data  (r_hold),
        .i_valid (r_hold_full),
        .o_ready (w_tx_ready),
        .o_txd   (w_txd)
    );

    assign bus.mem_rdata = r_rdata;
    assign leds          = r_leds;
    assign txd           = w_txd;

endmodule

// File: tb/tb_soc_io_uart_tx.sv
// tb/tb_soc_io_uart_tx.sv - directed self-checking bench for soc_io_uart_tx
module tb_soc_io_uart_tx;

    localparam logic [31:0] A_LEDS = 32'h0040_0004;
    localparam logic [31:0] A_DAT  = 32'h0040_0008;
    localparam logic [31:0] A_CNTL = 32'h0040_0010;

    logic       clk;
    logic       resetn;
    logic [4:0] leds;
    logic       txd;

    int n_tests;
    int n_fail;
    int lows;
    logic [7:0] rx_byte;
    logic       rx_start;
    logic       rx_stop;

    soc_io_uart_tx_if bus_if ();

    soc_io_uart_tx #(
        .CLK_FREQ (1000000),
        .BAUD     (100000)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if),
        .leds   (leds),
        .txd    (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus_if.mem_addr  = addr;
        bus_if.mem_wdata = data;
        bus_if.mem_wmask = 4'hF;
        tick();
        bus_if.mem_wmask = 4'h0;
    endtask

    task automatic rd(input logic [31:0] addr);
        bus_if.mem_addr  = addr;
        bus_if.mem_rstrb = 1'b1;
        tick();
        bus_if.mem_rstrb = 1'b0;
    endtask

    // Entered 4 cycles after txd fell; samples each bit 4 cycles into its
    // 10-cycle cell and leaves 94 cycles after the fall.
    task automatic sample_frame();
        rx_start = txd;
        for (int i = 0; i < 8; i++) begin
            repeat (10) tick();
            rx_byte[i] = txd;
        end
        repeat (10) tick();
        rx_stop = txd;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rx_byte = '0;
        resetn  = 1'b0;
        bus_if.mem_addr  = '0;
        bus_if.mem_wdata = '0;
        bus_if.mem_wmask = '0;
        bus_if.mem_rstrb = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        chk("reset_leds", 32'(leds), 32'h0);
        chk("reset_txd", 32'(txd), 32'h1);
        chk("reset_rdata", bus_if.mem_rdata, 32'h0);

        // LED register write and read-back
        wr(A_LEDS, 32'h0000_0015);
        chk("led_write", 32'(leds), 32'h15);
        rd(A_LEDS);
        chk("led_read", bus_if.mem_rdata, 32'h0000_0015);
        repeat (3) tick();
        chk("rdata_hold", bus_if.mem_rdata, 32'h0000_0015);
        rd(A_DAT);
        chk("read_uart_dat", bus_if.mem_rdata, 32'h0);
        rd(32'h0040_0000);
        chk("read_unmapped", bus_if.mem_rdata, 32'h0);

        // Single frame 0x41
        wr(A_DAT, 32'h41);
        chk("f41_no_fall_yet", 32'(txd), 32'h1);
        tick();
        chk("f41_fall", 32'(txd), 32'h0);
        repeat (4) tick();
        sample_frame();
        chk("f41_start", 32'(rx_start), 32'h0);
        chk("f41_data", 32'(rx_byte), 32'h41);
        chk("f41_stop", 32'(rx_stop), 32'h1);
        repeat (6) tick();
        chk("f41_idle_after", 32'(txd), 32'h1);

        // Busy flag, back-to-back frames, overflow drop
        wr(A_DAT, 32'h55);
        tick();
        chk("f55_fall", 32'(txd), 32'h0);
        wr(A_DAT, 32'hAA);
        rd(A_CNTL);
        chk("busy_while_held", bus_if.mem_rdata, 32'h0000_0200);
        wr(A_DAT, 32'h33);
        tick();
        sample_frame();
        chk("f55_start", 32'(rx_start), 32'h0);
        chk("f55_data", 32'(rx_byte), 32'h55);
        chk("f55_stop", 32'(rx_stop), 32'h1);
        repeat (6) tick();
        chk("gap_idle", 32'(txd), 32'h1);
        rd(A_CNTL);
        chk("busy_read_same_edge", bus_if.mem_rdata, 32'h0000_0200);
        chk("faa_fall", 32'(txd), 32'h0);
        rd(A_CNTL);
        chk("busy_clear", bus_if.mem_rdata, 32'h0);
        repeat (3) tick();
        sample_frame();
        chk("faa_start", 32'(rx_start), 32'h0);
        chk("faa_data", 32'(rx_byte), 32'hAA);
        chk("faa_stop", 32'(rx_stop), 32'h1);
        repeat (6) tick();
        lows = 0;
        for (int i = 0; i < 150; i++) begin
            if (txd !== 1'b1) lows++;
            tick();
        end
        chk("no_third_frame", 32'(lows), 32'h0);

        // Reset during DATA bit 3 with a byte waiting in hold
        wr(A_LEDS, 32'h0A);
        wr(A_DAT, 32'h3C);
        tick();
        chk("f3c_fall", 32'(txd), 32'h0);
        wr(A_DAT, 32'h99);
        repeat (44) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("rst_txd", 32'(txd), 32'h1);
        chk("rst_leds", 32'(leds), 32'h0);
        rd(A_CNTL);
        chk("rst_busy", bus_if.mem_rdata, 32'h0);
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            if (txd !== 1'b1) lows++;
            tick();
        end
        chk("rst_no_frame", 32'(lows), 32'h0);
        wr(A_DAT, 32'h0F);
        tick();
        chk("f0f_fall", 32'(txd), 32'h0);
        repeat (4) tick();
        sample_frame();
        chk("f0f_start", 32'(rx_start), 32'h0);
        chk("f0f_data", 32'(rx_byte), 32'h0F);
        chk("f0f_stop", 32'(rx_stop), 32'h1);
        repeat (6) tick();
        chk("f0f_idle_after", 32'(txd), 32'h1);

        // Accesses outside the IO page
        wr(A_LEDS, 32'h07);
        rd(A_LEDS);
        chk("pre_nonio_rdata", bus_if.mem_rdata, 32'h7);
        wr(32'h0000_0004, 32'h1F);
        chk("nonio_leds", 32'(leds), 32'h07);
        wr(32'h0000_0008, 32'h00);
        rd(32'h0000_0010);
        chk("nonio_rdata", bus_if.mem_rdata, 32'h7);
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            if (txd !== 1'b1) lows++;
            tick();
        end
        chk("nonio_txd", 32'(lows), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/soc_io_uart_tx.md
Name: soc_io_uart_tx

Overview:
- Memory-mapped IO responder for the RISC-V SoC CPU bus, which acts as the initiator.
- Decodes the IO page and owns the LED register plus an 8N1 UART transmitter that drives TXD.
- Replaces the constant TXD tie-off at SOC level.
- The CPU polls a status word and writes characters; the block serialises them at a fixed baud rate.

Parameters:
- CLK_FREQ, 48000000, frequency of clk in Hz.
- BAUD, 115200, UART bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD, clocks per UART bit (integer division; must be >= 2).

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- mem_addr  in  32  byte address from the CPU
- mem_wdata  in  32  write data
- mem_wmask  in  4  byte write enables; nonzero means write
- mem_rstrb  in  1  read strobe, one-cycle pulse
- mem_rdata  out  32  read data
- leds  out  5  LED register (active-high; SOC inverts)
- txd  out  1  UART serial output, idle high

Behaviour:
- Interface clock and reset: reset resetn, synchronous, active-low; clock clk.
- IO select: io_sel = mem_addr[22]. Word offset decode is one-hot on mem_addr[4:2]:
  - bit2 = LEDS
  - bit3 = UART_DATA
  - bit4 = UART_CNTL
- Writes with io_sel=0, or to unmapped offsets, are ignored.
- Write (io_sel && |mem_wmask):
  - LEDS: leds <= mem_wdata[4:0] on the next edge.
  - UART_DATA: if the holding register is empty, hold <= mem_wdata[7:0], hold_full <= 1. If hold_full=1, the write is dropped silently.
  - UART_CNTL: writes ignored.
- Read (io_sel && mem_rstrb): mem_rdata is registered and valid exactly 1 cycle after the strobe; it holds its value until the next strobe.
  - LEDS returns {27'b0, leds}.
  - UART_CNTL returns {22'b0, busy, 9'b0}, where busy = hold_full.
  - UART_DATA and unmapped offsets return 0.
  - A read with io_sel=0 leaves mem_rdata unchanged.
- TX FSM states: IDLE, START, DATA, STOP.
  - Bit counter: 3 bits. Baud counter: $clog2(CLKS_PER_BIT) bits.
  - IDLE: txd=1. If hold_full, load shift <= hold, clear hold_full, go to START with baud counter = 0.
  - START: txd=0 for CLKS_PER_BIT cycles, then DATA with bit=0.
  - DATA: txd=shift[0], LSB first. After CLKS_PER_BIT cycles, shift right and increment bit. After bit 7, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles, then IDLE.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - The first start-bit cycle occurs 2 cycles after the accepting UART_DATA write edge (1 cycle to hold, 1 cycle to load).
- Back-to-back frames:
  - A write during a frame fills hold and sets busy.
  - On the return to IDLE the next frame loads immediately. Only one IDLE cycle separates the stop bit from the next start bit.
- Simultaneous events:
  - If IDLE unloads hold in the same cycle a UART_DATA write arrives, the unload takes priority and the write is dropped (hold_full was still 1 when sampled).
  - A read of UART_CNTL in the same cycle as a write returns busy as it was before that edge.
- Reset values: leds=0, txd=1, mem_rdata=0, hold_full=0, state=IDLE, all counters 0.
- Reset mid-frame aborts the frame; txd returns high on the first reset edge.

Decomposition:
- Shared package holds:
  - IO address constants: IO_BIT=22, IO_LEDS_BIT=0, IO_UART_DAT_BIT=1, IO_UART_CNTL_BIT=2 (word-offset bit indices)
  - Status bit position UART_BUSY_BIT=9
  - TX state encoding localparams
- One sub-module, uart_tx_core, is natural: the FSM, shift register and baud counter, with interface {data[7:0], valid, ready, txd}.
- soc_io_uart_tx keeps the decode, LED register, holding register and read mux.

Test Plan:
1. LED register: CLK_FREQ=1000000, BAUD=100000 (10 clk/bit). Write 0x15 to 0x400004 with wmask=4'hF, then strobe a read. Response: leds=5'h15; mem_rdata=0x00000015 one cycle after the strobe.
2. Single frame: write 0x41 to 0x400008. Response:
   - txd falls 2 cycles later.
   - Sampling at bit centres gives 0,1,0,0,0,0,0,1,0,1 (start, LSB-first data, stop).
   - txd is high after 100 cycles.
3. Busy flag: write 0x55, then immediately write 0xAA. Poll UART_CNTL at 0x400010:
   - Reads 0x200 while 0xAA is held.
   - Reads 0 one cycle after 0xAA starts.
   - Both frames appear in order with a 1-cycle idle gap.
4. Overflow drop: with hold full, write 0x33. Response: no third frame; only 0x55 and 0xAA are transmitted.
5. Reset mid-frame: assert resetn=0 for 1 cycle during DATA bit 3. Response:
   - txd=1, busy=0, leds=0.
   - A subsequent write of 0x0F transmits a clean full frame.
6. Non-IO access: write 0x1F to 0x000004, then read 0x000010. Response: leds and mem_rdata unchanged; txd stays high.
